pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall sequencer for the 5-stage RV32I pipelined core. It owns the stall, flush and forward controls of the Fetch/Decode, Decode/Execute, Execute/Memory and Memory/Writeback pipeline registers. It resolves data hazards by forwarding or load-use bubbles, and control hazards by flushing. A small FSM holds the pipeline while the data memory has not acknowledged an access, with a timeout that parks the core in an error state.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive unacknowledged memory cycles tolerated in MEM_WAIT (≥1).
- CNT_W, 16: width of the stall performance counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rs1D, i_rs2D  in  5  Decode-stage source register indices.
- i_rs1E, i_rs2E  in  5  Execute-stage source register indices.
- i_rdE, i_rdM, i_rdW  in  5  destination register index in E, M and W.
- i_reg_writeM, i_reg_writeW  in  1  register write enable in M and W.
- i_result_srcE  in  2  ResultSrc in E; 2'b01 = load.
- i_pc_srcE  in  1  taken branch or jump resolved in E.
- i_mem_reqM  in  1  the M-stage instruction is a load or store.
- i_mem_ack  in  1  data memory has completed the M-stage access this cycle.
- o_stallF, o_stallD, o_stallE, o_stallM  out  1  hold the corresponding pipeline register.
- o_flushD, o_flushE, o_flushW  out  1  clear the corresponding pipeline register to a bubble.
- o_fwdAE, o_fwdBE  out  2  ALU operand select: 00 register file, 10 ALUResultM, 01 ResultW.
- o_state  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERR.
- o_mem_err  out  1  sticky memory timeout flag.
- o_stall_cnt  out  CNT_W  count of cycles with o_stallF=1, saturating.

## Operation
Internal conditions:
- mem_stall = i_mem_reqM & ~i_mem_ack, evaluated in RUN and MEM_WAIT.
- lw_stall = i_result_srcE==2'b01 & i_rdE!=0 & (i_rdE==i_rs1D | i_rdE==i_rs2D).

Forwarding, computed separately for rs1E and rs2E:
- 10 when i_reg_writeM & i_rdM!=0 & i_rdM==rsE.
- Otherwise 01 when i_reg_writeW & i_rdW!=0 & i_rdW==rsE.
- Otherwise 00. M always wins over W.
- Forwarding is independent of state.

Stall and flush outputs are listed by priority, highest first. Any signal not listed for a row is 0.
- ERR: stallF, stallD, stallE and stallM = 1, flushW = 1.
- mem_stall: stallF, stallD, stallE and stallM = 1, flushW = 1. A branch in E is held and is not flushed while stalled.
- i_pc_srcE: flushD = 1, flushE = 1. lw_stall is ignored because the dependent instruction is on the wrong path.
- lw_stall: stallF = 1, stallD = 1, flushE = 1.

FSM transitions:
- RUN → MEM_WAIT on mem_stall; wait_cnt ← 1.
- MEM_WAIT with mem_stall and wait_cnt < MAX_WAIT: stay; wait_cnt increments.
- MEM_WAIT with mem_stall and wait_cnt == MAX_WAIT: → ERR; o_mem_err ← 1.
- MEM_WAIT without mem_stall: → RUN; wait_cnt ← 0. This covers both an ack and i_mem_reqM dropping.
- ERR: absorbing. Only i_rst exits it.

Stall counter:
- o_stall_cnt increments every cycle o_stallF=1, including ERR cycles.
- It holds at 2^CNT_W−1 and does not wrap.

## Timing
- Reset, asynchronous: state=RUN, wait_cnt=0, o_mem_err=0, o_stall_cnt=0.
- While i_rst=1, all stall and flush outputs are forced to 0. Forward selects stay combinational.
- Stall, flush and forward outputs are combinational from the inputs and the current state, with zero-cycle latency. The stall asserts in the same cycle the hazard appears.
- o_state, o_mem_err and o_stall_cnt are registered. They change one edge after the causing condition.
- Memory handshake: i_mem_ack is sampled every cycle i_mem_reqM=1.
  - An ack in the same cycle as the request gives no stall and no state change.
  - An ack after N≥1 wait cycles releases all stalls in the ack cycle. The FSM returns to RUN on the next edge.
- Timeout: o_mem_err rises after MAX_WAIT+1 consecutive cycles with mem_stall=1. An ack arriving in the cycle where wait_cnt==MAX_WAIT prevents ERR.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately and clears all flags.

## Test plan
- Forwarding: i_rdM=5, i_reg_writeM=1, i_rdW=5, i_reg_writeW=1, i_rs1E=5 → o_fwdAE=10. Same stimulus with i_rdM=0 → o_fwdAE=01. With i_rs2E=0 and i_rdW=0 → o_fwdBE=00.
- Load-use: i_result_srcE=01, i_rdE=7, i_rs2D=7 → stallF=1, stallD=1, flushE=1 for one cycle, o_stall_cnt += 1. Adding i_pc_srcE=1 in the same cycle → flushD=1, flushE=1, stallF=0.
- Memory wait: i_mem_reqM=1 with i_mem_ack low for 3 cycles, then high → all four stalls and flushW held for 3 cycles. o_state=01 on cycles 2–4. o_state returns to 00 after the ack edge. o_stall_cnt=3.
- Timeout with MAX_WAIT=15: i_mem_reqM=1, i_mem_ack=0 held → o_mem_err=1 and o_state=10 after the 16th edge. Stalls stay asserted after the request drops. A second run with the ack on the 16th cycle (wait_cnt=15) → no error, return to RUN.
- Reset mid-operation: assert i_rst in MEM_WAIT at wait_cnt=4 → immediately state=00, all stall and flush outputs 0, o_stall_cnt=0.
- Counter saturation with CNT_W=4: hold a stall for 20 cycles → o_stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath (master) and
// the hazard sequencer (slave). Clock and reset travel as plain ports.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_rs1D;
  logic [4:0]       i_rs2D;
  logic [4:0]       i_rs1E;
  logic [4:0]       i_rs2E;
  logic [4:0]       i_rdE;
  logic [4:0]       i_rdM;
  logic [4:0]       i_rdW;
  logic             i_reg_writeM;
  logic             i_reg_writeW;
  logic [1:0]       i_result_srcE;
  logic             i_pc_srcE;
  // Memory handshake: i_mem_reqM acts as valid and i_mem_ack as ready. The
  // M-stage access completes in the cycle both are high; req without ack holds the pipe.
  logic             i_mem_reqM;
  logic             i_mem_ack;

  logic             o_stallF;
  logic             o_stallD;
  logic             o_stallE;
  logic             o_stallM;
  logic             o_flushD;
  logic             o_flushE;
  logic             o_flushW;
  logic [1:0]       o_fwdAE;
  logic [1:0]       o_fwdBE;
  logic [1:0]       o_state;
  logic             o_mem_err;
  logic [CNT_W-1:0] o_stall_cnt;

  modport master (
    output i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_rdM, i_rdW,
    output i_reg_writeM, i_reg_writeW, i_result_srcE, i_pc_srcE,
    output i_mem_reqM, i_mem_ack,
    input  o_stallF, o_stallD, o_stallE, o_stallM,
    input  o_flushD, o_flushE, o_flushW, o_fwdAE, o_fwdBE,
    input  o_state, o_mem_err, o_stall_cnt
  );

  modport slave (
    input  i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_rdM, i_rdW,
    input  i_reg_writeM, i_reg_writeW, i_result_srcE, i_pc_srcE,
    input  i_mem_reqM, i_mem_ack,
    output o_stallF, o_stallD, o_stallE, o_stallM,
    output o_flushD, o_flushE, o_flushW, o_fwdAE, o_fwdBE,
    output o_state, o_mem_err, o_stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32I pipeline: forwarding,
// load-use bubbles, branch flushes and a memory-wait FSM with timeout.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic lw_stall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(hz.i_rs1E, hz.i_reg_writeM, hz.i_rdM, hz.i_reg_writeW, hz.i_rdW);
    fwd_b = fwd_sel(hz.i_rs2E, hz.i_reg_writeM, hz.i_rdM, hz.i_reg_writeW, hz.i_rdW);
  end

  assign mem_stall = hz.i_mem_reqM & ~hz.i_mem_ack;
  assign lw_stall  = (hz.i_result_srcE == 2'b01) && (hz.i_rdE != 5'd0) &&
                     ((hz.i_rdE == hz.i_rs1D) || (hz.i_rdE == hz.i_rs2D));

  // Priority: ERR / memory hold > taken branch > load-use bubble.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (i_rst) begin
      stall_f = 1'b0;
    end else if ((state_q == ST_ERR) || mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.i_pc_srcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WW'(1);
        end
      end
      ST_WAIT: begin
        if (!mem_stall) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WW'(MAX_WAIT)) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.o_stallF    = stall_f;
  assign hz.o_stallD    = stall_d;
  assign hz.o_stallE    = stall_e;
  assign hz.o_stallM    = stall_m;
  assign hz.o_flushD    = flush_d;
  assign hz.o_flushE    = flush_e;
  assign hz.o_flushW    = flush_w;
  assign hz.o_fwdAE     = fwd_a;
  assign hz.o_fwdBE     = fwd_b;
  assign hz.o_state     = state_q;
  assign hz.o_mem_err   = mem_err_q;
  assign hz.o_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .hz    (hz)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // streak = consecutive cycles the memory has held the pipe; timeout after MAX_WAIT+1.
  int m_streak = 0;
  bit m_err    = 1'b0;
  int m_cnt    = 0;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (hz.i_reg_writeM && hz.i_rdM != 0 && hz.i_rdM == rs) return 2'b10;
    if (hz.i_reg_writeW && hz.i_rdW != 0 && hz.i_rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  function automatic logic [6:0] exp_ctl();
    bit mem, lw;
    if (i_rst) return 7'b0;
    mem = hz.i_mem_reqM && !hz.i_mem_ack;
    lw  = hz.i_result_srcE == 2'b01 && hz.i_rdE != 0 &&
          (hz.i_rdE == hz.i_rs1D || hz.i_rdE == hz.i_rs2D);
    if (m_err || mem)  return 7'b1111_001;
    if (hz.i_pc_srcE)  return 7'b0000_110;
    if (lw)            return 7'b1100_010;
    return 7'b0;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_err) return 2'b10;
    return (m_streak > 0) ? 2'b01 : 2'b00;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    logic [6:0] c;
    if (i_rst) begin
      m_streak = 0;
      m_err    = 1'b0;
      m_cnt    = 0;
    end else begin
      c = exp_ctl();
      if (c[6] && m_cnt < CNT_MAX) m_cnt++;
      if (!m_err) begin
        if (hz.i_mem_reqM && !hz.i_mem_ack) begin
          m_streak++;
          if (m_streak == MAX_WAIT + 1) m_err = 1'b1;
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  function automatic logic [6:0] dut_ctl();
    return {hz.o_stallF, hz.o_stallD, hz.o_stallE, hz.o_stallM,
            hz.o_flushD, hz.o_flushE, hz.o_flushW};
  endfunction

  // ---------------- compare process (scoreboard) ----------------
  always @(negedge i_clk) begin
    if (chk_on) begin
      check("ctl",   32'(dut_ctl()),       32'(exp_ctl()));
      check("fwdA",  32'(hz.o_fwdAE),      32'(exp_fwd(hz.i_rs1E)));
      check("fwdB",  32'(hz.o_fwdBE),      32'(exp_fwd(hz.i_rs2E)));
      check("state", 32'(hz.o_state),      32'(exp_state()));
      check("err",   32'(hz.o_mem_err),    32'(m_err));
      check("cnt",   32'(hz.o_stall_cnt),  32'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    hz.i_rs1D = 0; hz.i_rs2D = 0; hz.i_rs1E = 0; hz.i_rs2E = 0;
    hz.i_rdE = 0; hz.i_rdM = 0; hz.i_rdW = 0;
    hz.i_reg_writeM = 0; hz.i_reg_writeW = 0; hz.i_result_srcE = 0;
    hz.i_pc_srcE = 0; hz.i_mem_reqM = 0; hz.i_mem_ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b1;
    cyc(2);
    i_rst = 1'b0;
  endtask

  task automatic drive_random();
    hz.i_rs1D = 5'($urandom_range(0, 3)); hz.i_rs2D = 5'($urandom_range(0, 3));
    hz.i_rs1E = 5'($urandom_range(0, 3)); hz.i_rs2E = 5'($urandom_range(0, 3));
    hz.i_rdE  = 5'($urandom_range(0, 3)); hz.i_rdM  = 5'($urandom_range(0, 3));
    hz.i_rdW  = 5'($urandom_range(0, 3));
    hz.i_reg_writeM  = 1'($urandom_range(0, 1));
    hz.i_reg_writeW  = 1'($urandom_range(0, 1));
    hz.i_result_srcE = 2'($urandom_range(0, 3));
    hz.i_pc_srcE     = ($urandom_range(0, 5) == 0);
    hz.i_mem_reqM    = ($urandom_range(0, 2) == 0);
    hz.i_mem_ack     = ($urandom_range(0, 1) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    #1 i_rst = 1'b1;
    chk_on = 1'b1;
    cyc(2);
    #1;
    check("rst_state", 32'(hz.o_state), 32'd0);
    check("rst_ctl",   32'(dut_ctl()), 32'd0);
    check("rst_cnt",   32'(hz.o_stall_cnt), 32'd0);
    i_rst = 1'b0;
    cyc(1);

    // Forwarding priority
    hz.i_rdM = 5; hz.i_reg_writeM = 1; hz.i_rdW = 5; hz.i_reg_writeW = 1; hz.i_rs1E = 5;
    #1 check("fwd_m_wins", 32'(hz.o_fwdAE), 32'b10);
    hz.i_rdM = 0;
    #1 check("fwd_w", 32'(hz.o_fwdAE), 32'b01);
    hz.i_rs2E = 0; hz.i_rdW = 0;
    #1 check("fwd_none", 32'(hz.o_fwdBE), 32'b00);
    clear_inputs();
    cyc(1);

    // Load-use bubble, then branch overriding it
    hz.i_result_srcE = 2'b01; hz.i_rdE = 7; hz.i_rs2D = 7;
    #1 check("lw_ctl", 32'(dut_ctl()), 32'b1100_010);
    cyc(1);
    check("lw_cnt", 32'(hz.o_stall_cnt), 32'd1);
    hz.i_pc_srcE = 1;
    #1 check("br_over_lw", 32'(dut_ctl()), 32'b0000_110);
    cyc(1);
    check("br_cnt", 32'(hz.o_stall_cnt), 32'd1);
    clear_inputs();

    // Memory wait of 3 cycles
    hz.i_mem_reqM = 1;
    #1 check("mw_ctl", 32'(dut_ctl()), 32'b1111_001);
    check("mw_st0", 32'(hz.o_state), 32'd0);
    cyc(1);
    check("mw_st1", 32'(hz.o_state), 32'd1);
    cyc(2);
    hz.i_mem_ack = 1;
    #1 check("mw_ack_ctl", 32'(dut_ctl()), 32'd0);
    check("mw_ack_st", 32'(hz.o_state), 32'd1);
    cyc(1);
    clear_inputs();
    check("mw_run", 32'(hz.o_state), 32'd0);
    check("mw_cnt", 32'(hz.o_stall_cnt), 32'd4);

    // Timeout into ERR
    hz.i_mem_reqM = 1;
    cyc(15);
    check("to_pre_err", 32'(hz.o_mem_err), 32'd0);
    check("to_pre_st",  32'(hz.o_state), 32'd1);
    cyc(1);
    check("to_err", 32'(hz.o_mem_err), 32'd1);
    check("to_st",  32'(hz.o_state), 32'd2);
    hz.i_mem_reqM = 0;
    #1 check("err_hold", 32'(dut_ctl()), 32'b1111_001);
    cyc(1);
    check("err_sat_cnt", 32'(hz.o_stall_cnt), 32'd15);

    // Ack arriving at wait_cnt == MAX_WAIT averts the error
    do_reset();
    hz.i_mem_reqM = 1;
    cyc(15);
    hz.i_mem_ack = 1;
    #1 check("late_ack_ctl", 32'(dut_ctl()), 32'd0);
    cyc(1);
    check("late_ack_st",  32'(hz.o_state), 32'd0);
    check("late_ack_err", 32'(hz.o_mem_err), 32'd0);
    clear_inputs();

    // Async reset mid MEM_WAIT
    do_reset();
    hz.i_mem_reqM = 1;
    cyc(4);
    check("mid_st", 32'(hz.o_state), 32'd1);
    #2 i_rst = 1'b1;
    #1 check("mid_rst_st",  32'(hz.o_state), 32'd0);
    check("mid_rst_ctl", 32'(dut_ctl()), 32'd0);
    check("mid_rst_cnt", 32'(hz.o_stall_cnt), 32'd0);
    clear_inputs();
    cyc(1);
    i_rst = 1'b0;

    // Counter saturation
    hz.i_result_srcE = 2'b01; hz.i_rdE = 3; hz.i_rs1D = 3;
    cyc(10);
    check("sat_10", 32'(hz.o_stall_cnt), 32'd10);
    cyc(10);
    check("sat_20", 32'(hz.o_stall_cnt), 32'd15);
    clear_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 150) == 0) i_rst = ~i_rst;
      else if (i_rst && $urandom_range(0, 3) == 0) i_rst = 1'b0;
      drive_random();
      cyc(1);
    end
    i_rst = 1'b0;
    clear_inputs();
    cyc(2);
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
